// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO bus controller.
// Optional feature macro: GPIO_SHADOW_READBACK_EN (shadow readback of OUT/DIR).
package gpio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StWHold,
        StRSel,
        StRCap,
        StAck
    } gpio_bus_state_t;

    localparam logic [63:0] GPIO_OFF_OUT  = 64'h00;
    localparam logic [63:0] GPIO_OFF_DIR  = 64'h08;
    localparam logic [63:0] GPIO_OFF_IN   = 64'h10;
    localparam logic [63:0] GPIO_WIN_SIZE = 64'h18;

endpackage

// File: rtl/gpio_addr_decode.sv
// Combinational decode of a CPU address against the GPIO register window.
// Optional feature macro: GPIO_SHADOW_READBACK_EN (OUT/DIR loads become mapped).
module gpio_addr_decode
    import gpio_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic              hit_out,
    output logic              hit_dir,
    output logic              hit_in,
    output logic              unmapped
);

    logic [ADDR_W-1:0] offset;
    logic              in_win;
    logic              any_hit;

    // Addresses below the base wrap to huge offsets, so one compare bounds both ends.
    always_comb begin
        offset   = addr - BASE_ADDR[ADDR_W-1:0];
        in_win   = offset < ADDR_W'(GPIO_WIN_SIZE);
        hit_out  = in_win && (offset == ADDR_W'(GPIO_OFF_OUT));
        hit_dir  = in_win && (offset == ADDR_W'(GPIO_OFF_DIR));
        hit_in   = in_win && (offset == ADDR_W'(GPIO_OFF_IN));
        any_hit  = hit_out || hit_dir || hit_in;
`ifdef GPIO_SHADOW_READBACK_EN
        unmapped = !any_hit || (we && hit_in);
`else
        unmapped = !any_hit || (we && hit_in) || (!we && (hit_out || hit_dir));
`endif
    end

endmodule

// File: rtl/gpio_bus_controller.sv
// CPU req/ack to GPIO peripheral strobe sequencer with a shared tri-state data bus.
// Optional feature macro: GPIO_SHADOW_READBACK_EN (OUT/DIR shadow registers readable).
module gpio_bus_controller
    import gpio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000,
    parameter int unsigned NUM_IO    = 13,
    parameter int unsigned ADDR_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [63:0]       cpu_rdata,
    output logic              busy,
    inout  wire  [63:0]       data_bus,
    output logic              CS,
    output logic              LOAD_OUT,
    output logic              LOAD_DIR,
    output logic              READ_IN
);

    localparam logic [63:0] IO_MASK = (NUM_IO >= 64) ? {64{1'b1}} :
                                      ((64'd1 << NUM_IO) - 64'd1);

    gpio_bus_state_t state;
    logic            hit_out, hit_dir, hit_in, unmapped;
    logic            sel_out, sel_dir;
    logic [63:0]     wdata_q;
    logic            drive;

    gpio_addr_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .addr     (cpu_addr),
        .we       (cpu_we),
        .hit_out  (hit_out),
        .hit_dir  (hit_dir),
        .hit_in   (hit_in),
        .unmapped (unmapped)
    );

`ifdef GPIO_SHADOW_READBACK_EN
    logic [NUM_IO-1:0] out_shadow, dir_shadow;

    // Shadows take the write data as the write enters W_STROBE.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_shadow <= '0;
            dir_shadow <= '0;
        end else if (state == StWSetup) begin
            if (sel_out) out_shadow <= wdata_q[NUM_IO-1:0];
            if (sel_dir) dir_shadow <= wdata_q[NUM_IO-1:0];
        end
    end
`endif

    assign busy     = (state != StIdle);
    assign data_bus = drive ? wdata_q : {64{1'bz}};

    // Transaction FSM; all strobes and CPU responses are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            CS        <= 1'b0;
            LOAD_OUT  <= 1'b0;
            LOAD_DIR  <= 1'b0;
            READ_IN   <= 1'b0;
            drive     <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            sel_out   <= 1'b0;
            sel_dir   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            LOAD_OUT <= 1'b0;
            LOAD_DIR <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cpu_req) begin
                        sel_out   <= hit_out;
                        sel_dir   <= hit_dir;
                        wdata_q   <= cpu_wdata;
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b0;
                        if (unmapped) begin
                            state   <= StAck;
                            cpu_err <= 1'b1;
                            cpu_ack <= 1'b1;
                        end else if (cpu_we) begin
                            state <= StWSetup;
                            CS    <= 1'b1;
                            drive <= 1'b1;
                        end else if (hit_in) begin
                            state   <= StRSel;
                            CS      <= 1'b1;
                            READ_IN <= 1'b1;
                        end else begin
`ifdef GPIO_SHADOW_READBACK_EN
                            state     <= StAck;
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= hit_out ? 64'(out_shadow) : 64'(dir_shadow);
`else
                            // Unreachable: decode flags OUT/DIR loads as unmapped.
                            state   <= StAck;
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
`endif
                        end
                    end
                end
                StWSetup: begin
                    state    <= StWStrobe;
                    LOAD_OUT <= sel_out;
                    LOAD_DIR <= sel_dir;
                end
                StWStrobe: state <= StWHold;
                StWHold: begin
                    state   <= StAck;
                    CS      <= 1'b0;
                    drive   <= 1'b0;
                    cpu_ack <= 1'b1;
                end
                StRSel: state <= StRCap;
                StRCap: begin
                    state     <= StAck;
                    CS        <= 1'b0;
                    READ_IN   <= 1'b0;
                    cpu_rdata <= data_bus & IO_MASK;
                    cpu_ack   <= 1'b1;
                end
                StAck: begin
                    state   <= StIdle;
                    cpu_err <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_controller.sv
// Directed self-checking bench for gpio_bus_controller.
// Optional feature macro: GPIO_SHADOW_READBACK_EN (changes OUT/DIR load expectations).
module tb_gpio_bus_controller;

    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
`ifdef GPIO_SHADOW_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_err, busy;
    logic [63:0] cpu_rdata;
    wire  [63:0] data_bus;
    logic        CS, LOAD_OUT, LOAD_DIR, READ_IN;
    logic        tb_drive;
    logic [63:0] tb_val;

    int checks    = 0;
    int failures  = 0;
    int excl_errs = 0;

    assign data_bus = tb_drive ? tb_val : {64{1'bz}};

    gpio_bus_controller #(
        .BASE_ADDR (BASE),
        .NUM_IO    (13),
        .ADDR_W    (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .busy      (busy),
        .data_bus  (data_bus),
        .CS        (CS),
        .LOAD_OUT  (LOAD_OUT),
        .LOAD_DIR  (LOAD_DIR),
        .READ_IN   (READ_IN)
    );

    always #5 clock = ~clock;

    // Strobe exclusivity and strobe-under-CS, sampled every cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if ((int'(LOAD_OUT) + int'(LOAD_DIR) + int'(READ_IN)) > 1 ||
                ((LOAD_OUT || LOAD_DIR || READ_IN) && !CS))
                excl_errs++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic released();
        return (data_bus === {64{1'bz}}) || (data_bus === 64'h0);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] busval,
                           input logic hold, input int exp_lat, input int exp_cs,
                           input int exp_lo, input int exp_ld, input int exp_ri,
                           input int exp_st, input logic [63:0] exp_rdata,
                           input logic exp_err);
        int          lat = 0, cs_n = 0, lo_n = 0, ld_n = 0, ri_n = 0, st_at = 0;
        logic        bus_ok = 1'b1, got_ack = 1'b0, er = 1'b0;
        logic [63:0] rd = '0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tb_val    = busval;
        while (!got_ack && lat < 16) begin
            tick();
            lat++;
            tb_drive = READ_IN;
            #1;
            cs_n += int'(CS);
            lo_n += int'(LOAD_OUT);
            ld_n += int'(LOAD_DIR);
            ri_n += int'(READ_IN);
            if (LOAD_OUT || LOAD_DIR) st_at = lat;
            if (CS && !READ_IN) bus_ok &= (data_bus === wdata);
            else if (!CS) bus_ok &= released();
            if (cpu_ack) begin
                got_ack = 1'b1;
                rd      = cpu_rdata;
                er      = cpu_err;
                if (!hold) cpu_req = 1'b0;
            end
        end
        if (!got_ack) cpu_req = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".cs_cycles"}, 64'(cs_n), 64'(exp_cs));
        check({tag, ".load_out_cycles"}, 64'(lo_n), 64'(exp_lo));
        check({tag, ".load_dir_cycles"}, 64'(ld_n), 64'(exp_ld));
        check({tag, ".read_in_cycles"}, 64'(ri_n), 64'(exp_ri));
        check({tag, ".strobe_cycle"}, 64'(st_at), 64'(exp_st));
        check({tag, ".rdata"}, rd, exp_rdata);
        check({tag, ".err"}, 64'(er), 64'(exp_err));
        check({tag, ".bus"}, 64'(bus_ok), 64'd1);
        if (!hold) begin
            tick();
            check({tag, ".ack_one_cycle"}, 64'(cpu_ack), 64'd0);
            check({tag, ".idle_after"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        tb_drive  = 1'b0;
        tb_val    = '0;
        tick();
        tick();
        check("rst.cs", 64'(CS), 64'd0);
        check("rst.strobes", {61'd0, LOAD_OUT, LOAD_DIR, READ_IN}, 64'd0);
        check("rst.ack", 64'(cpu_ack), 64'd0);
        check("rst.err", 64'(cpu_err), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.rdata", cpu_rdata, 64'd0);
        check("rst.bus", 64'(released()), 64'd1);
        reset = 1'b0;
        tick();

        run_txn("st_out", 1'b1, BASE + 64'h00, 64'hDEAD_BEEF_0000_1ABC, 64'h0, 1'b0,
                4, 3, 1, 0, 0, 2, 64'h0, 1'b0);
        run_txn("st_dir", 1'b1, BASE + 64'h08, 64'h0000_0000_0000_00FF, 64'h0, 1'b0,
                4, 3, 0, 1, 0, 2, 64'h0, 1'b0);
        run_txn("ld_dir", 1'b0, BASE + 64'h08, 64'hCAFE, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, RB ? 64'h00FF : 64'h0, !RB);
        run_txn("ld_out", 1'b0, BASE + 64'h00, 64'hCAFE, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, RB ? 64'h1ABC : 64'h0, !RB);
        run_txn("ld_in", 1'b0, BASE + 64'h10, 64'hCAFE, 64'hFFFF_FFFF_FFFF_0A55, 1'b0,
                3, 2, 0, 0, 2, 0, 64'h0A55, 1'b0);
        run_txn("st_in", 1'b1, BASE + 64'h10, 64'h1234, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, 64'h0, 1'b1);
        run_txn("ld_0x20", 1'b0, BASE + 64'h20, 64'h5678, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, 64'h0, 1'b1);
        run_txn("ld_below", 1'b0, BASE - 64'h08, 64'h5678, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, 64'h0, 1'b1);
        run_txn("st_misalign", 1'b1, BASE + 64'h04, 64'h9ABC, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, 64'h0, 1'b1);

        // Reset while the OUT strobe is high aborts the write without an ack.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = BASE;
        cpu_wdata = 64'h0123;
        tick();
        tick();
        check("abort.strobe_seen", 64'(LOAD_OUT), 64'd1);
        check("abort.busy_mid", 64'(busy), 64'd1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        tick();
        check("abort.cs", 64'(CS), 64'd0);
        check("abort.strobes", {61'd0, LOAD_OUT, LOAD_DIR, READ_IN}, 64'd0);
        check("abort.ack", 64'(cpu_ack), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.bus", 64'(released()), 64'd1);
        reset = 1'b0;
        tick();
        tick();
        check("abort.no_late_ack", 64'(cpu_ack), 64'd0);
        run_txn("st_after", 1'b1, BASE, 64'h0456, 64'h0, 1'b0,
                4, 3, 1, 0, 0, 2, 64'h0, 1'b0);
        run_txn("ld_after", 1'b0, BASE, 64'h0, 64'h0, 1'b0,
                1, 0, 0, 0, 0, 0, RB ? 64'h0456 : 64'h0, !RB);

        // Back-to-back with cpu_req held: second write starts the cycle after ACK.
        run_txn("b2b_1", 1'b1, BASE + 64'h00, 64'h0005, 64'h0, 1'b1,
                4, 3, 1, 0, 0, 2, 64'h0, 1'b0);
        run_txn("b2b_2", 1'b1, BASE + 64'h08, 64'h000A, 64'h0, 1'b0,
                5, 3, 0, 1, 0, 3, 64'h0, 1'b0);

        check("strobe_exclusive", 64'(excl_errs), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
